// File: rtl/loader_pkg.sv
// loader_pkg: shared constants and types for the instruction loader (frame header, FSM states, byte-lane index)
package loader_pkg;
  localparam logic [7:0] HDR_DEF = 8'hA5;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  typedef logic [1:0] lane_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles 4 accepted bytes little-endian into a word; ports clk, reset (async active-low), clr (frame start), acc (byte accepted), din, word, word_valid (pulse on 4th byte)
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        acc,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);
  lane_t       lane;
  logic [23:0] sr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lane <= '0;
      sr   <= '0;
    end else if (clr) begin
      lane <= '0;
      sr   <= '0;
    end else if (acc) begin
      lane <= lane + 1'b1;
      sr   <= {din, sr[23:8]};
    end
  assign word       = {din, sr};
  assign word_valid = acc && lane == 2'd3;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: framed byte stream to instruction memory writer; ports clk, reset (async active-low), in_data/in_valid/in_ready (byte stream), mem_we/mem_waddr/mem_wdata (memory write port), cpu_hold, done, err; optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module instr_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] HDR    = HDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  localparam logic [16:0] MAXN = 17'd1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CSUM;
`else
  localparam state_t FIN = DONE;
`endif
  state_t      state, nxt;
  logic        xfer, start, word_valid;
  logic [31:0] word;
  logic [7:0]  len_lo;
  logic [16:0] n, nwords, wcnt;
  assign n        = {1'b0, in_data, len_lo};
  assign in_ready = reset && state != DONE;
  assign xfer     = in_valid && in_ready;
  assign cpu_hold = state != IDLE;
  assign done     = state == DONE;
  assign err      = state == ERR;
  byte_packer u_pack (
    .clk       (clk),
    .reset     (reset),
    .clr       (start),
    .acc       (xfer && state == DATA),
    .din       (in_data),
    .word      (word),
    .word_valid(word_valid)
  );
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge reset)
    if (!reset) csum <= '0;
    else if (start) csum <= '0;
    else if (xfer && (state == LEN0 || state == LEN1 || state == DATA)) csum <= csum ^ in_data;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt   = state;
    start = 1'b0;
    case (state)
      IDLE, ERR: if (xfer && in_data == HDR) begin
        nxt   = LEN0;
        start = 1'b1;
      end
      LEN0: nxt = xfer ? LEN1 : LEN0;
      LEN1: nxt = !xfer ? LEN1 : n > MAXN ? ERR : n == '0 ? FIN : DATA;
      DATA: nxt = word_valid && wcnt + 17'd1 == nwords ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
      CSUM: nxt = !xfer ? CSUM : in_data == csum ? DONE : ERR;
`endif
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // wcnt is both the words-written count and the next write address
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      wcnt      <= '0;
      nwords    <= '0;
      len_lo    <= '0;
    end else begin
      mem_we <= word_valid;
      if (word_valid) begin
        mem_waddr <= wcnt[ADDR_W-1:0];
        mem_wdata <= word;
      end
      wcnt <= start ? '0 : wcnt + {16'd0, word_valid};
      if (xfer && state == LEN0) len_lo <= in_data;
      if (xfer && state == LEN1) nwords <= n;
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench for instr_loader against a frame-level model
module tb_instr_loader;
  localparam int         AW  = 8;
  localparam logic [7:0] HDR = 8'hA5;
  logic          clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, mem_we, cpu_hold, done, err;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  int            tests = 0, fails = 0, cyc = 0, done_cnt = 0;
  int            wq_addr[$], wq_cyc[$], acc_q[$], exp_addr[$];
  logic [31:0]   wq_data[$], exp_words[$];
  logic [31:0]   mem [2**AW];
  logic [7:0]    payload[$];
  logic          hold_after_hdr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum_x, cs_adj = '0;
`endif

  instr_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(int'(mem_waddr));
      wq_data.push_back(mem_wdata);
      wq_cyc.push_back(cyc);
      mem[mem_waddr] = mem_wdata;
    end
    if (done) done_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout byte=%h in_ready=%b want 1", b, in_ready);
    end
    acc_q.push_back(cyc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n);
    acc_q.delete();
    send_byte(HDR);
    hold_after_hdr = cpu_hold;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (payload[i]) send_byte(payload[i]);
`ifdef LOADER_CHECKSUM_EN
    csum_x = n[7:0] ^ n[15:8];
    foreach (payload[i]) csum_x ^= payload[i];
    send_byte(csum_x ^ cs_adj);
`endif
  endtask

  // model: word i = bytes 4i..4i+3 weighted little-endian, written to address i
  task automatic build_payload(input int n);
    longint w;
    payload.delete();
    for (int j = 0; j < 4 * n; j++) payload.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < n; i++) begin
      w = 0;
      for (int k = 3; k >= 0; k--) w = w * 256 + longint'(payload[4*i+k]);
      exp_words.push_back(32'(w));
      exp_addr.push_back(i);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready, mem_we, cpu_hold, done, err, mem_waddr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h want all 0",
               in_ready, mem_we, cpu_hold, done, err, mem_waddr, mem_wdata);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    int w0, d0;
    payload.delete();
    exp_words.delete();
    exp_addr.delete();
    payload = '{8'h13, 8'h00, 8'h00, 8'h00};
    exp_words.push_back(32'h0000_0013);
    exp_addr.push_back(0);
    w0 = wq_addr.size();
    d0 = done_cnt;
    send_frame(16'd1);
    repeat (3) @(negedge clk);
    tests++;
    if (wq_addr.size() - w0 !== 1) begin
      fails++;
      $display("FAIL single_wcount got %0d want 1", wq_addr.size() - w0);
    end else begin
      tests++;
      if (wq_addr[w0] !== exp_addr[0] || wq_data[w0] !== exp_words[0] || wq_cyc[w0] !== acc_q[6] + 1) begin
        fails++;
        $display("FAIL single_write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 wq_addr[w0], wq_data[w0], wq_cyc[w0], exp_addr[0], exp_words[0], acc_q[6] + 1);
      end
    end
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL single_done got %0d pulses want 1", done_cnt - d0);
    end
    tests++;
    if (hold_after_hdr !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL single_hold got hdr_hold=%b end_hold=%b err=%b want 1 0 0", hold_after_hdr, cpu_hold, err);
    end
  endtask

  task automatic test_multi;
    for (int r = 0; r < 5; r++) begin
      int n, w0, d0;
      n = r == 0 ? 3 : r == 4 ? 256 : int'($urandom_range(1, 9));
      exp_words.delete();
      exp_addr.delete();
      build_payload(n);
      w0 = wq_addr.size();
      d0 = done_cnt;
      send_frame(16'(n));
      repeat (3) @(negedge clk);
      tests++;
      if (wq_addr.size() - w0 !== n) begin
        fails++;
        $display("FAIL multi_wcount n=%0d got %0d want %0d", n, wq_addr.size() - w0, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          tests++;
          if (wq_addr[w0+i] !== exp_addr[i] || wq_data[w0+i] !== exp_words[i] || wq_cyc[w0+i] !== acc_q[6+4*i] + 1) begin
            fails++;
            $display("FAIL multi_write n=%0d i=%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                     n, i, wq_addr[w0+i], wq_data[w0+i], wq_cyc[w0+i], exp_addr[i], exp_words[i], acc_q[6+4*i] + 1);
          end
        end
      end
      tests++;
      if (done_cnt - d0 !== 1 || cpu_hold !== 1'b0 || hold_after_hdr !== 1'b1) begin
        fails++;
        $display("FAIL multi_end n=%0d got done=%0d hold=%b hdr_hold=%b want 1 0 1", n, done_cnt - d0, cpu_hold, hold_after_hdr);
      end
    end
  endtask

  task automatic test_junk;
    int w0, d0;
    logic [7:0] b;
    w0 = wq_addr.size();
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      b = i == 0 ? 8'h00 : i == 1 ? 8'hFF : 8'($urandom_range(0, 255));
      if (b == HDR) b = 8'h5A;
      send_byte(b);
      tests++;
      if (cpu_hold !== 1'b0) begin
        fails++;
        $display("FAIL junk_hold byte=%h got %b want 0", b, cpu_hold);
      end
    end
    payload.delete();
    send_frame(16'd0);
    repeat (3) @(negedge clk);
    tests++;
    if (wq_addr.size() - w0 !== 0 || done_cnt - d0 !== 1 || err !== 1'b0) begin
      fails++;
      $display("FAIL junk_empty_frame got writes=%0d done=%0d err=%b want 0 1 0", wq_addr.size() - w0, done_cnt - d0, err);
    end
  endtask

  task automatic test_len_err;
    int w0, d0;
    w0 = wq_addr.size();
    send_byte(HDR);
    send_byte(8'h01);
    send_byte(8'h01);
    tests++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL len257_err got err=%b hold=%b rdy=%b want 1 1 1", err, cpu_hold, in_ready);
    end
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    tests++;
    if (err !== 1'b1 || wq_addr.size() - w0 !== 0) begin
      fails++;
      $display("FAIL len257_stay got err=%b writes=%0d want 1 0", err, wq_addr.size() - w0);
    end
    exp_words.delete();
    exp_addr.delete();
    build_payload(1);
    d0 = done_cnt;
    send_frame(16'd1);
    repeat (3) @(negedge clk);
    tests++;
    if (err !== 1'b0 || done_cnt - d0 !== 1 || wq_addr.size() - w0 !== 1) begin
      fails++;
      $display("FAIL err_recover got err=%b done=%0d writes=%0d want 0 1 1", err, done_cnt - d0, wq_addr.size() - w0);
    end else begin
      tests++;
      if (wq_addr[w0] !== 0 || wq_data[w0] !== exp_words[0]) begin
        fails++;
        $display("FAIL err_recover_write got addr=%0d data=%h want 0 %h", wq_addr[w0], wq_data[w0], exp_words[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int w0, d0, last1;
    exp_words.delete();
    exp_addr.delete();
    w0 = wq_addr.size();
    d0 = done_cnt;
    build_payload(2);
    send_frame(16'd2);
    last1 = acc_q[acc_q.size()-1];
    build_payload(1);
    send_frame(16'd1);
    repeat (3) @(negedge clk);
    tests++;
    if (acc_q[0] - last1 !== 2) begin
      fails++;
      $display("FAIL b2b_gap got %0d cycles want 2", acc_q[0] - last1);
    end
    tests++;
    if (done_cnt - d0 !== 2 || wq_addr.size() - w0 !== 3) begin
      fails++;
      $display("FAIL b2b_counts got done=%0d writes=%0d want 2 3", done_cnt - d0, wq_addr.size() - w0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (wq_addr[w0+k] !== exp_addr[k] || wq_data[w0+k] !== exp_words[k]) begin
          fails++;
          $display("FAIL b2b_write k=%0d got addr=%0d data=%h want %0d %h", k, wq_addr[w0+k], wq_data[w0+k], exp_addr[k], exp_words[k]);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    int w0, d0;
    exp_words.delete();
    exp_addr.delete();
    build_payload(2);
    w0 = wq_addr.size();
    send_byte(HDR);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int j = 0; j < 6; j++) send_byte(payload[j]);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({in_ready, mem_we, cpu_hold, done, err, mem_waddr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h want all 0",
               in_ready, mem_we, cpu_hold, done, err, mem_waddr, mem_wdata);
    end
    tests++;
    if (wq_addr.size() - w0 !== 1 || mem[0] !== exp_words[0]) begin
      fails++;
      $display("FAIL midreset_word0 got writes=%0d mem0=%h want 1 %h", wq_addr.size() - w0, mem[0], exp_words[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_words.delete();
    exp_addr.delete();
    build_payload(1);
    w0 = wq_addr.size();
    d0 = done_cnt;
    send_frame(16'd1);
    repeat (3) @(negedge clk);
    tests++;
    if (wq_addr.size() - w0 !== 1 || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL midreset_next got writes=%0d done=%0d want 1 1", wq_addr.size() - w0, done_cnt - d0);
    end else begin
      tests++;
      if (wq_addr[w0] !== 0 || wq_data[w0] !== exp_words[0]) begin
        fails++;
        $display("FAIL midreset_next_write got addr=%0d data=%h want 0 %h", wq_addr[w0], wq_data[w0], exp_words[0]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_csum;
    int w0, d0;
    payload = '{8'h13, 8'h00, 8'h00, 8'h00};
    cs_adj = 8'h00;
    d0 = done_cnt;
    send_frame(16'd1);
    repeat (3) @(negedge clk);
    tests++;
    if (csum_x !== 8'h12 || done_cnt - d0 !== 1 || err !== 1'b0) begin
      fails++;
      $display("FAIL csum_good got csum=%h done=%0d err=%b want 12 1 0", csum_x, done_cnt - d0, err);
    end
    cs_adj = 8'h12;
    w0 = wq_addr.size();
    d0 = done_cnt;
    send_frame(16'd1);
    repeat (3) @(negedge clk);
    tests++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || done_cnt - d0 !== 0 || wq_addr.size() - w0 !== 1) begin
      fails++;
      $display("FAIL csum_bad got err=%b hold=%b done=%0d writes=%0d want 1 1 0 1", err, cpu_hold, done_cnt - d0, wq_addr.size() - w0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_junk();
    test_len_err();
    test_back_to_back();
    test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
    test_csum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
